// File: rtl/stage_dot_accumulator.sv
// stage_dot_accumulator: first-stage dot-product engine.
// Streams signed element pairs, accumulates their products per vector and
// emits one scaled fixed-point result per vector over valid/ready.
// Optional build macro: STAGE_SATURATE_EN (clamp results instead of wrapping).
module stage_dot_accumulator #(
    parameter  int unsigned DATA_W    = 16,
    parameter  int unsigned ACC_W     = 32,
    parameter  int unsigned NUM_A     = 4,
    parameter  int unsigned NUM_B     = 4,
    parameter  int unsigned FRAC_BITS = 0,
    localparam int unsigned A_SEL_W   = (NUM_A > 1) ? $clog2(NUM_A) : 1,
    localparam int unsigned LAYER_W   = (NUM_B > 1) ? $clog2(NUM_B) : 1
) (
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic                      go,
    input  logic [A_SEL_W-1:0]        a_sel,
    input  logic [NUM_A*DATA_W-1:0]   a_bus,
    input  logic [NUM_B*DATA_W-1:0]   b_bus,
    input  logic                      in_valid,
    input  logic                      last_element,
    output logic                      in_ready,
    output logic [LAYER_W-1:0]        layer,
    output logic                      busy,
    output logic [DATA_W-1:0]         z_data,
    output logic                      z_valid,
    input  logic                      z_ready,
    output logic                      done
);

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_B - 1);

`ifdef STAGE_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [LAYER_W-1:0]         layer_q, layer_d;
    logic [DATA_W-1:0]          z_data_q, z_data_d;
    logic                       z_valid_q, z_valid_d;
    logic                       done_q, done_d;

    logic signed [DATA_W-1:0]   a_op;
    logic signed [DATA_W-1:0]   b_op;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum;
    logic                       beat;
    logic                       z_hs;
    logic [LAYER_W-1:0]         layer_inc;

    // Scale by FRAC_BITS, then reduce to DATA_W bits (clamp or wrap).
    function automatic logic [DATA_W-1:0] fmt(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] sh;
        sh = x >>> FRAC_BITS;
`ifdef STAGE_SATURATE_EN
        if (sh > SAT_MAX) begin
            sh = SAT_MAX;
        end else if (sh < SAT_MIN) begin
            sh = SAT_MIN;
        end
`endif
        return DATA_W'(sh);
    endfunction

    // A operand mux; out-of-range selects fall back to channel 0.
    always_comb begin
        a_op = a_bus[DATA_W-1:0];
        for (int unsigned k = 1; k < NUM_A; k++) begin
            if (a_sel == A_SEL_W'(k)) begin
                a_op = a_bus[k*DATA_W +: DATA_W];
            end
        end
    end

    // B operand mux driven by the active layer.
    always_comb begin
        b_op = b_bus[DATA_W-1:0];
        for (int unsigned k = 1; k < NUM_B; k++) begin
            if (layer_q == LAYER_W'(k)) begin
                b_op = b_bus[k*DATA_W +: DATA_W];
            end
        end
    end

    assign prod      = a_op * b_op;
    assign prod_ext  = ACC_W'(prod);
    assign sum       = acc_q + prod_ext;
    assign layer_inc = (layer_q == LAST_LAYER) ? '0 : layer_q + LAYER_W'(1);

    // Input side stalls while a result is waiting on a blocked consumer.
    assign in_ready = (state_q == RUN) && !(z_valid_q && !z_ready);
    assign beat     = in_valid && in_ready;
    assign z_hs     = z_valid_q && z_ready;

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        layer_d   = layer_q;
        z_data_d  = z_data_q;
        z_valid_d = z_valid_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = RUN;
                    acc_d   = '0;
                    layer_d = '0;
                end
            end
            RUN: begin
                if (z_hs) begin
                    z_valid_d = 1'b0;
                end
                if (beat) begin
                    if (last_element) begin
                        acc_d     = '0;
                        z_data_d  = fmt(sum);
                        z_valid_d = 1'b1;
                        layer_d   = layer_inc;
                        if (layer_q == LAST_LAYER) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            FLUSH: begin
                if (z_hs) begin
                    z_valid_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            layer_q   <= '0;
            z_data_q  <= '0;
            z_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            layer_q   <= layer_d;
            z_data_q  <= z_data_d;
            z_valid_q <= z_valid_d;
            done_q    <= done_d;
        end
    end

    assign layer   = layer_q;
    assign busy    = (state_q != IDLE);
    assign z_data  = z_data_q;
    assign z_valid = z_valid_q;
    assign done    = done_q;

endmodule
